// File: rtl/data_stack_pkg.sv
// Shared opcode encoding and sizing helper for the data_stack block.
package data_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_PUSH        = 3'd1,
    OP_POP         = 3'd2,
    OP_REPLACE     = 3'd3,
    OP_POP_REPLACE = 3'd4
  } op_e;

  // An entry count of 0..depth needs one bit more than an index into depth.
  function automatic int depth_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/data_stack_ram.sv
// Backing store for elements below TOS/NOS: one synchronous write port,
// one asynchronous read port.
module stack_ram #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 62,
  parameter int AW      = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_stack.sv
// Hardware data stack with TOS/NOS held in registers and deeper entries in stack_ram.
// Sticky overflow/underflow flags exist only when DATA_STACK_GUARD_EN is defined.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     c_CLOCK,
  input  logic                     f_RESET,
  input  logic [2:0]               i_OP,
  input  logic [WIDTH-1:0]         i_DATA,
  input  logic                     f_CLRERR,
  output logic [WIDTH-1:0]         o_OP1,
  output logic [WIDTH-1:0]         o_OP2,
  output logic [$clog2(DEPTH):0]   o_DEPTH,
  output logic                     o_EMPTY,
  output logic                     o_FULL,
  output logic                     o_OVERFLOW,
  output logic                     o_UNDERFLOW
);

  localparam int DW      = depth_bits(DEPTH);
  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = $clog2(ENTRIES);

  logic [WIDTH-1:0] tos, nos;
  logic [DW-1:0]    depth;
  logic [DW-1:0]    sp;
  logic             is_empty, is_full, two_or_more;
  logic             push_ok, pop_ok, rep_ok, popr_ok;
  logic             err_ovf, err_unf;
  logic             ram_wr_en, have_third;
  logic [WIDTH-1:0] ram_rd_data, third;

  assign is_empty    = (depth == '0);
  assign is_full     = (depth == DW'(DEPTH));
  assign two_or_more = (depth >= DW'(2));

  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    rep_ok  = 1'b0;
    popr_ok = 1'b0;
    err_ovf = 1'b0;
    err_unf = 1'b0;
    case (i_OP)
      OP_PUSH:        if (!is_full)   push_ok = 1'b1; else err_ovf = 1'b1;
      OP_POP:         if (!is_empty)  pop_ok  = 1'b1; else err_unf = 1'b1;
      OP_REPLACE:     if (!is_empty)  rep_ok  = 1'b1; else err_unf = 1'b1;
      OP_POP_REPLACE: if (two_or_more) popr_ok = 1'b1; else err_unf = 1'b1;
      default: ;
    endcase
  end

  // sp counts entries spilled to the RAM; the third element lives at sp-1.
  assign ram_wr_en  = push_ok && two_or_more;
  assign have_third = (sp != '0);
  assign third      = have_third ? ram_rd_data : '0;

  stack_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_ram (
    .clk     (c_CLOCK),
    .wr_en   (ram_wr_en),
    .wr_addr (AW'(sp)),
    .wr_data (nos),
    .rd_addr (AW'(sp - DW'(1))),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge c_CLOCK) begin
    if (f_RESET) begin
      tos   <= '0;
      nos   <= '0;
      depth <= '0;
      sp    <= '0;
    end else if (push_ok) begin
      tos   <= i_DATA;
      nos   <= tos;
      depth <= depth + DW'(1);
      if (ram_wr_en) sp <= sp + DW'(1);
    end else if (pop_ok || popr_ok) begin
      tos   <= pop_ok ? nos : i_DATA;
      nos   <= third;
      depth <= depth - DW'(1);
      if (have_third) sp <= sp - DW'(1);
    end else if (rep_ok) begin
      tos <= i_DATA;
    end
  end

  assign o_OP1   = tos;
  assign o_OP2   = nos;
  assign o_DEPTH = depth;
  assign o_EMPTY = is_empty;
  assign o_FULL  = is_full;

`ifdef DATA_STACK_GUARD_EN
  logic ovf, unf;

  // A fresh error wins over a simultaneous clear.
  always_ff @(posedge c_CLOCK) begin
    if (f_RESET) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (err_ovf)       ovf <= 1'b1;
      else if (f_CLRERR) ovf <= 1'b0;
      if (err_unf)       unf <= 1'b1;
      else if (f_CLRERR) unf <= 1'b0;
    end
  end

  assign o_OVERFLOW  = ovf;
  assign o_UNDERFLOW = unf;
`else
  logic unused_guard;
  assign unused_guard = ^{f_CLRERR, err_ovf, err_unf};
  assign o_OVERFLOW   = 1'b0;
  assign o_UNDERFLOW  = 1'b0;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack (WIDTH=16, DEPTH=4): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
`ifdef DATA_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] data = '0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] op1, op2;
  logic [2:0]       dep;
  logic             empty, full, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] st[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .c_CLOCK     (clk),
    .f_RESET     (rst),
    .i_OP        (op),
    .i_DATA      (data),
    .f_CLRERR    (clr),
    .o_OP1       (op1),
    .o_OP2       (op2),
    .o_DEPTH     (dep),
    .o_EMPTY     (empty),
    .o_FULL      (full),
    .o_OVERFLOW  (ovf),
    .o_UNDERFLOW (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic model_step(input logic [2:0] o, input logic [WIDTH-1:0] d,
                            input logic r, input logic c);
    bit eo, eu;
    eo = 0; eu = 0;
    if (r) begin
      st.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    case (o)
      3'd1: if (st.size() < DEPTH) st.push_back(d); else eo = 1;
      3'd2: if (st.size() >= 1) void'(st.pop_back()); else eu = 1;
      3'd3: if (st.size() >= 1) st[st.size()-1] = d; else eu = 1;
      3'd4: if (st.size() >= 2) begin void'(st.pop_back()); st[st.size()-1] = d; end
            else eu = 1;
      default: ;
    endcase
    if (GUARD) begin
      if (c) begin m_ovf = 0; m_unf = 0; end
      if (eo) m_ovf = 1;
      if (eu) m_unf = 1;
    end
  endtask

  function automatic logic [WIDTH-1:0] m_op1();
    return (st.size() >= 1) ? st[st.size()-1] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] m_op2();
    return (st.size() >= 2) ? st[st.size()-2] : '0;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d,
                       input logic r = 1'b0, input logic c = 1'b0);
    @(negedge clk);
    op = o; data = d; rst = r; clr = c;
    @(posedge clk);
    #1;
    model_step(o, d, r, c);
  endtask

  task automatic test_reset();
    do_op(3'd1, 16'h1234, 1'b1);
    n_tests++;
    if ({dep, empty, full, op1, op2, ovf, unf} !== {3'd0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got depth=%0d empty=%b full=%b op1=%h op2=%h ovf=%b unf=%b, required 0 1 0 0000 0000 0 0",
               dep, empty, full, op1, op2, ovf, unf);
    end
  endtask

  task automatic test_pop_replace();
    do_op(3'd0, 0, 1'b1);
    do_op(3'd1, 16'h0001);
    do_op(3'd1, 16'h0002);
    do_op(3'd1, 16'h0003);
    n_tests++;
    if ({op1, op2, dep} !== {16'h0003, 16'h0002, 3'd3}) begin
      n_fail++;
      $display("FAIL push3: got op1=%h op2=%h depth=%0d, required 0003 0002 3", op1, op2, dep);
    end
    do_op(3'd4, 16'h0005);
    n_tests++;
    if ({op1, op2, dep} !== {16'h0005, 16'h0001, 3'd2}) begin
      n_fail++;
      $display("FAIL pop_replace: got op1=%h op2=%h depth=%0d, required 0005 0001 2", op1, op2, dep);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq[0] = 16'h0003; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0001; exp_seq[3] = 16'h0000;
    do_op(3'd0, 0, 1'b1);
    for (int i = 1; i <= 4; i++) do_op(3'd1, WIDTH'(i));
    do_op(3'd1, 16'h00FF);
    n_tests++;
    if ({dep, full, empty, op1, op2, ovf} !== {3'd4, 1'b1, 1'b0, 16'h0004, 16'h0003, GUARD}) begin
      n_fail++;
      $display("FAIL overflow: got depth=%0d full=%b empty=%b op1=%h op2=%h ovf=%b, required 4 1 0 0004 0003 %b",
               dep, full, empty, op1, op2, ovf, GUARD);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(3'd2, 16'hDEAD);
      n_tests++;
      if (op1 !== exp_seq[i] || dep !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL pop_seq[%0d]: got op1=%h depth=%0d, required %h %0d", i, op1, dep, exp_seq[i], 3 - i);
      end
    end
    n_tests++;
    if ({empty, full, op2} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL drained: got empty=%b full=%b op2=%h, required 1 0 0000", empty, full, op2);
    end
  endtask

  task automatic test_underflow_clear();
    do_op(3'd0, 0, 1'b1);
    do_op(3'd2, 0, 1'b0, 1'b1);
    n_tests++;
    if ({unf, ovf, dep} !== {GUARD, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL underflow_with_clr: got unf=%b ovf=%b depth=%0d, required %b 0 0", unf, ovf, dep, GUARD);
    end
    do_op(3'd0, 0, 1'b0, 1'b1);
    n_tests++;
    if (unf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone: got unf=%b, required 0", unf);
    end
  endtask

  task automatic test_popr_depth1();
    do_op(3'd0, 0, 1'b1);
    do_op(3'd1, 16'h0007);
    do_op(3'd4, 16'h0009);
    n_tests++;
    if ({unf, op1, op2, dep} !== {GUARD, 16'h0007, 16'h0000, 3'd1}) begin
      n_fail++;
      $display("FAIL popr_depth1: got unf=%b op1=%h op2=%h depth=%0d, required %b 0007 0000 1", unf, op1, op2, dep, GUARD);
    end
    do_op(3'd3, 16'h0009);
    n_tests++;
    if ({op1, dep} !== {16'h0009, 3'd1}) begin
      n_fail++;
      $display("FAIL replace: got op1=%h depth=%0d, required 0009 1", op1, dep);
    end
    do_op(3'd7, 16'h0123);
    n_tests++;
    if ({op1, dep, ovf} !== {16'h0009, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL op7_nop: got op1=%h depth=%0d ovf=%b, required 0009 1 0", op1, dep, ovf);
    end
  endtask

  task automatic test_reset_midseq();
    do_op(3'd0, 0, 1'b1);
    do_op(3'd1, 16'h0001);
    do_op(3'd1, 16'h0002);
    do_op(3'd1, 16'h0003);
    do_op(3'd1, 16'h00AA, 1'b1);
    n_tests++;
    if ({dep, op1, op2, empty} !== {3'd0, 16'h0000, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midseq: got depth=%0d op1=%h op2=%h empty=%b, required 0 0000 0000 1", dep, op1, op2, empty);
    end
    do_op(3'd1, 16'h0011);
    n_tests++;
    if ({op1, op2, dep} !== {16'h0011, 16'h0000, 3'd1}) begin
      n_fail++;
      $display("FAIL push_after_reset: got op1=%h op2=%h depth=%0d, required 0011 0000 1", op1, op2, dep);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] o;
    logic       r, c;
    do_op(3'd0, 0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = 3'd1;
      r = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 7) == 0);
      do_op(o, WIDTH'($urandom), r, c);
      n_tests++;
      if ({op1, op2, dep, empty, full} !==
          {m_op1(), m_op2(), 3'(st.size()), st.size() == 0, st.size() == DEPTH}) begin
        n_fail++;
        $display("FAIL random_data[%0d]: got op1=%h op2=%h depth=%0d empty=%b full=%b, required %h %h %0d %b %b",
                 i, op1, op2, dep, empty, full, m_op1(), m_op2(), st.size(), st.size() == 0, st.size() == DEPTH);
      end
      n_tests++;
      if ({ovf, unf} !== {m_ovf, m_unf}) begin
        n_fail++;
        $display("FAIL random_flags[%0d]: got ovf=%b unf=%b, required %b %b", i, ovf, unf, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pop_replace();
    test_overflow();
    test_underflow_clear();
    test_popr_depth1();
    test_reset_midseq();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
